// File: rtl/accel_sha256_core.sv
// Iterative SHA-256 compression engine: one round per cycle, result streamed as eight digest words plus a status word.
// Build option: define SHA_DOUBLE_EN to include the double-hash (second pass) path.
module accel_sha256_core #(
  parameter logic [15:0] CTRL_ADDR   = 16'hF000,
  parameter logic [15:0] RESULT_BASE = 16'hF010,
  parameter logic [15:0] STATUS_ADDR = 16'hF018
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_wrt_en,
  input  logic [31:0]  cpu_wrt_data,
  input  logic [15:0]  cpu_addr,
  input  logic [511:0] accel_rd_data,
  output logic         accel_wrt_en,
  output logic [15:0]  accel_addr,
  output logic [31:0]  accel_wrt_data
);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, WRITE, STATUS} state_t;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        cont_q, cont_d;
  logic [31:0] work_q [8];
  logic [31:0] work_d [8];
  logic [31:0] hinit_q [8];
  logic [31:0] hinit_d [8];
  logic [31:0] hprev_q [8];
  logic [31:0] hprev_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] hsum [8];
  logic        en_q, en_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] t1, t2;
  logic        cmd_accept;

`ifdef SHA_DOUBLE_EN
  logic dbl_q, dbl_d;
  logic unused_bits;
  assign unused_bits = &{1'b0, cpu_wrt_data[31:3]};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, cpu_wrt_data[31:2]};
`endif

  assign cmd_accept = cpu_wrt_en && (cpu_addr == CTRL_ADDR) && cpu_wrt_data[0] && (state_q == IDLE);

  always_comb begin
    for (int i = 0; i < 8; i++) hsum[i] = hinit_q[i] + work_q[i];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    work_d  = work_q;
    hinit_d = hinit_q;
    hprev_d = hprev_q;
    w_d     = w_q;
    en_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    t1      = work_q[7] + bsig1(work_q[4]) + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
              + K[cnt_q] + w_q[0];
    t2      = bsig0(work_q[0]) + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
`ifdef SHA_DOUBLE_EN
    dbl_d   = dbl_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d = LOAD;
          cont_d  = cpu_wrt_data[1];
`ifdef SHA_DOUBLE_EN
          dbl_d   = cpu_wrt_data[2];
`endif
          for (int i = 0; i < 16; i++) w_d[i] = accel_rd_data[511-32*i -: 32];
        end
      end
      LOAD: begin
        for (int i = 0; i < 8; i++) begin
          hinit_d[i] = cont_q ? hprev_q[i] : IV[i];
          work_d[i]  = cont_q ? hprev_q[i] : IV[i];
        end
        cnt_d   = '0;
        state_d = ROUND;
      end
      ROUND: begin
        work_d[0] = t1 + t2;
        work_d[1] = work_q[0];
        work_d[2] = work_q[1];
        work_d[3] = work_q[2];
        work_d[4] = work_q[3] + t1;
        work_d[5] = work_q[4];
        work_d[6] = work_q[5];
        work_d[7] = work_q[6];
        // Rolling schedule: slot 0 always holds W[t]; slot 15 receives W[t+16].
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        hprev_d = hsum;
        cnt_d   = '0;
        state_d = WRITE;
        en_d    = 1'b1;
        addr_d  = RESULT_BASE;
        data_d  = hsum[0];
`ifdef SHA_DOUBLE_EN
        if (dbl_q) begin
          dbl_d   = 1'b0;
          cont_d  = 1'b0;
          state_d = LOAD;
          en_d    = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          for (int i = 0; i < 8; i++) w_d[i] = hsum[i];
          w_d[8] = 32'h8000_0000;
          for (int i = 9; i < 15; i++) w_d[i] = '0;
          w_d[15] = 32'h0000_0100;
        end
`endif
      end
      WRITE: begin
        // Output registers run one word ahead of cnt_q so each strobe lands in its WRITE cycle.
        en_d = 1'b1;
        if (cnt_q[2:0] == 3'd7) begin
          state_d = STATUS;
          addr_d  = STATUS_ADDR;
          data_d  = 32'h0000_0001;
        end else begin
          addr_d  = RESULT_BASE + {10'd0, cnt_q} + 16'd1;
          data_d  = hprev_q[cnt_q[2:0] + 3'd1];
          cnt_d   = cnt_q + 6'd1;
        end
      end
      STATUS: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        hprev_q[i] <= IV[i];
        hinit_q[i] <= '0;
        work_q[i]  <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
`ifdef SHA_DOUBLE_EN
      dbl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hprev_q <= hprev_d;
      hinit_q <= hinit_d;
      work_q  <= work_d;
      w_q     <= w_d;
`ifdef SHA_DOUBLE_EN
      dbl_q   <= dbl_d;
`endif
    end
  end

  assign accel_wrt_en   = en_q;
  assign accel_addr     = addr_q;
  assign accel_wrt_data = data_q;

endmodule

// File: tb/tb_accel_sha256_core.sv
// Self-checking bench for accel_sha256_core: known SHA-256 vectors plus random blocks against a
// straightforward full-schedule compression model.
module tb_accel_sha256_core;

  logic         clk;
  logic         rst_n;
  logic         cpu_wrt_en;
  logic [31:0]  cpu_wrt_data;
  logic [15:0]  cpu_addr;
  logic [511:0] accel_rd_data;
  logic         accel_wrt_en;
  logic [15:0]  accel_addr;
  logic [31:0]  accel_wrt_data;

  accel_sha256_core dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_wrt_en(cpu_wrt_en),
    .cpu_wrt_data(cpu_wrt_data),
    .cpu_addr(cpu_addr),
    .accel_rd_data(accel_rd_data),
    .accel_wrt_en(accel_wrt_en),
    .accel_addr(accel_addr),
    .accel_wrt_data(accel_wrt_data)
  );

  localparam logic [255:0] IV_WORDS = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] ABC_BLOCK   = {32'h6162_6380, 448'd0, 32'h0000_0018};
  localparam logic [511:0] EMPTY_BLOCK = {32'h8000_0000, 480'd0};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DBL_DIGEST =
    256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;

  int          checkCount;
  int          errorCount;
  int          cycleCnt;
  int          seenCycle [$];
  logic [15:0] seenAddr [$];
  logic [31:0] seenData [$];
  logic [255:0] modelPrev;

  // Free-running clock and a cycle counter that names cycles the same way the timing rules do
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Every result strobe is logged with its cycle so runs can be checked after the fact
  always @(negedge clk) begin
    if (accel_wrt_en === 1'b1) begin
      seenCycle.push_back(cycleCnt);
      seenAddr.push_back(accel_addr);
      seenData.push_back(accel_wrt_data);
    end
  end

  // Watchdog so a stuck bench still terminates with a visible failure
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: expands the full 64-word schedule up front, then runs the rounds
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] h [8];
    logic [31:0] s0, s1, tmp1, tmp2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) begin
      h[i] = hin[255-32*i -: 32];
      v[i] = h[i];
    end
    for (int t = 0; t < 64; t++) begin
      tmp1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
             + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KTAB[t] + w[t];
      tmp2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
             + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + tmp1;
      v[0] = tmp1 + tmp2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[i] + v[i];
    return res;
  endfunction

  task automatic checkValue(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one write on the CPU bus during cycle atCycle (or immediately if already past it)
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] cmd, input logic [511:0] blk,
                               input int atCycle, output int issued);
    while (cycleCnt < atCycle) @(negedge clk);
    cpu_wrt_en    = 1'b1;
    cpu_addr      = addr;
    cpu_wrt_data  = cmd;
    accel_rd_data = blk;
    issued        = cycleCnt;
    @(negedge clk);
    cpu_wrt_en    = 1'b0;
    cpu_wrt_data  = '0;
  endtask

  // Expects exactly eight digest strobes from cmdCycle+lat and the status strobe right after
  task automatic checkOutput(input string tag, input logic [255:0] digest, input int cmdCycle, input int lat);
    logic [79:0] obs, exp;
    while (cycleCnt < cmdCycle + lat + 10) @(negedge clk);
    checkValue({tag, "_count"}, 80'(seenCycle.size()), 80'd9);
    for (int i = 0; i < 9; i++) begin
      obs = (i < seenCycle.size()) ? {32'(seenCycle[i]), seenAddr[i], seenData[i]} : '0;
      if (i < 8) exp = {32'(cmdCycle + lat + i), 16'(16'hF010 + i), digest[255-32*i -: 32]};
      else       exp = {32'(cmdCycle + lat + 8), 16'hF018, 32'h0000_0001};
      checkValue($sformatf("%s_w%0d", tag, i), obs, exp);
    end
    seenCycle.delete();
    seenAddr.delete();
    seenData.delete();
  endtask

  initial begin
    int n, m, dummy;
    logic [511:0] blk;
    logic [255:0] expD;
    logic contBit;

    checkCount    = 0;
    errorCount    = 0;
    rst_n         = 1'b0;
    cpu_wrt_en    = 1'b0;
    cpu_wrt_data  = '0;
    cpu_addr      = '0;
    accel_rd_data = '0;
    modelPrev     = IV_WORDS;

    repeat (3) @(negedge clk);
    checkValue("reset_en", 80'(accel_wrt_en), 80'd0);
    checkValue("reset_addr", 80'(accel_addr), 80'd0);
    checkValue("reset_data", 80'(accel_wrt_data), 80'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known vectors
    applyStimulus(16'hF000, 32'h1, ABC_BLOCK, 0, n);
    checkOutput("abc", ABC_DIGEST, n, 67);
    modelPrev = ABC_DIGEST;
    applyStimulus(16'hF000, 32'h1, EMPTY_BLOCK, 0, n);
    checkOutput("empty", EMPTY_DIGEST, n, 67);
    modelPrev = EMPTY_DIGEST;

    // Starts while busy and in the STATUS cycle are dropped; the first IDLE cycle accepts
    applyStimulus(16'hF000, 32'h1, ABC_BLOCK, 0, n);
    applyStimulus(16'hF000, 32'h1, EMPTY_BLOCK, n + 10, dummy);
    applyStimulus(16'hF000, 32'h1, EMPTY_BLOCK, n + 75, dummy);
    checkOutput("busy", ABC_DIGEST, n, 67);
    while (cycleCnt < n + 160) @(negedge clk);
    checkValue("busy_late", 80'(seenCycle.size()), 80'd0);
    applyStimulus(16'hF000, 32'h1, ABC_BLOCK, 0, n);
    applyStimulus(16'hF000, 32'h1, EMPTY_BLOCK, n + 76, m);
    checkOutput("b2b_first", ABC_DIGEST, n, 67);
    checkOutput("b2b_second", EMPTY_DIGEST, m, 67);

    // Chaining from the previous digest, then an unchained run
    applyStimulus(16'hF000, 32'h1, ABC_BLOCK, 0, n);
    checkOutput("chain_base", ABC_DIGEST, n, 67);
    expD = compress(ABC_DIGEST, ABC_BLOCK);
    applyStimulus(16'hF000, 32'h3, ABC_BLOCK, 0, n);
    checkOutput("chain", expD, n, 67);
    applyStimulus(16'hF000, 32'h1, ABC_BLOCK, 0, n);
    checkOutput("unchain", ABC_DIGEST, n, 67);
    modelPrev = ABC_DIGEST;

    // Random blocks with random chaining
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom();
      contBit = 1'($urandom_range(0, 1));
      expD = compress(contBit ? modelPrev : IV_WORDS, blk);
      applyStimulus(16'hF000, {30'd0, contBit, 1'b1}, blk, 0, n);
      checkOutput($sformatf("rand%0d", k), expD, n, 67);
      modelPrev = expD;
    end

    // Reset during round 30 aborts; a stray start to another address is ignored
    applyStimulus(16'hF000, 32'h1, ABC_BLOCK, 0, n);
    while (cycleCnt < n + 32) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkValue("abort_en", 80'(accel_wrt_en), 80'd0);
    m = cycleCnt;
    applyStimulus(16'hF004, 32'h1, EMPTY_BLOCK, m + 20, dummy);
    while (cycleCnt < m + 100) @(negedge clk);
    checkValue("abort_quiet", 80'(seenCycle.size()), 80'd0);
    modelPrev = IV_WORDS;
    applyStimulus(16'hF000, 32'h3, ABC_BLOCK, 0, n);
    checkOutput("after_reset", ABC_DIGEST, n, 67);

`ifdef SHA_DOUBLE_EN
    applyStimulus(16'hF000, 32'h5, ABC_BLOCK, 0, n);
    checkOutput("double", DBL_DIGEST, n, 133);
    expD = compress(DBL_DIGEST, EMPTY_BLOCK);
    applyStimulus(16'hF000, 32'h3, EMPTY_BLOCK, 0, n);
    checkOutput("double_chain", expD, n, 67);
`else
    applyStimulus(16'hF000, 32'h5, ABC_BLOCK, 0, n);
    checkOutput("dbl_ignored", ABC_DIGEST, n, 67);
    checkValue("dbl_model", 80'(compress(IV_WORDS, {ABC_DIGEST, 32'h8000_0000, 192'd0, 32'h0000_0100}) != DBL_DIGEST),
               80'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
